// File: rtl/bist_pattern_gen.sv
// Logic BIST stimulus generator: 16-bit Fibonacci LFSR feeding a scan sequencer
// that shifts, captures and unloads patterns while steering the downstream MISR.
module bist_pattern_gen #(
    parameter int unsigned CHAIN_LENGTH = 32,
    parameter int unsigned NUM_PATTERNS = 64,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        scan_in,
    output logic        scan_en,
    output logic        capture,
    output logic        misr_clear,
    output logic        misr_enable,
    output logic        busy,
    output logic        done,
    output logic [15:0] pattern_count
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_SHIFT   = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [CNT_W-1:0] LAST_PATTERN = CNT_W'(NUM_PATTERNS);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        FLUSH   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_n;
    logic [CNT_W-1:0] shift_cnt;
    logic [CNT_W-1:0] shift_cnt_n;
    logic [CNT_W-1:0] pcount_n;
    logic             scan_in_n;
    logic             scan_en_n;
    logic             capture_n;
    logic             misr_clear_n;
    logic             misr_enable_n;
    logic             busy_n;
    logic             done_n;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // State, datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= SEED_EFF;
            shift_cnt     <= '0;
            pattern_count <= '0;
            scan_in       <= 1'b0;
            scan_en       <= 1'b0;
            capture       <= 1'b0;
            misr_clear    <= 1'b0;
            misr_enable   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            lfsr          <= lfsr_n;
            shift_cnt     <= shift_cnt_n;
            pattern_count <= pcount_n;
            scan_in       <= scan_in_n;
            scan_en       <= scan_en_n;
            capture       <= capture_n;
            misr_clear    <= misr_clear_n;
            misr_enable   <= misr_enable_n;
            busy          <= busy_n;
            done          <= done_n;
        end
    end

    // Next state and next-cycle output decode
    always_comb begin
        state_n      = state;
        lfsr_n       = lfsr;
        shift_cnt_n  = shift_cnt;
        pcount_n     = pattern_count;
        misr_clear_n = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = SHIFT;
                    lfsr_n       = SEED_EFF;
                    shift_cnt_n  = '0;
                    pcount_n     = '0;
                    misr_clear_n = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_n = lfsr_step(lfsr);
                if (shift_cnt == LAST_SHIFT) begin
                    shift_cnt_n = '0;
                    state_n     = CAPTURE;
                end else begin
                    shift_cnt_n = shift_cnt + 16'd1;
                end
            end
            CAPTURE: begin
                if (pattern_count != LAST_PATTERN) begin
                    pcount_n = pattern_count + 16'd1;
                end
                if (pcount_n == LAST_PATTERN) begin
                    state_n = FLUSH;
                end else begin
                    state_n = SHIFT;
                end
            end
            FLUSH: begin
                lfsr_n = lfsr_step(lfsr);
                if (shift_cnt == LAST_SHIFT) begin
                    shift_cnt_n = '0;
                    state_n     = DONE;
                end else begin
                    shift_cnt_n = shift_cnt + 16'd1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        scan_en_n     = (state_n == SHIFT) || (state_n == FLUSH);
        scan_in_n     = scan_en_n & lfsr_n[0];
        capture_n     = (state_n == CAPTURE);
        // Chain content before the first capture is undefined, so keep it out of the MISR
        misr_enable_n = ((state_n == SHIFT) && (pcount_n != '0)) || (state_n == FLUSH);
        busy_n        = (state_n == SHIFT) || (state_n == CAPTURE) || (state_n == FLUSH);
        done_n        = (state_n == DONE);
    end

endmodule
